// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Purpose  : RV32I/RV-A instruction decoder feeding an in-order buffer of
//            decoded entries, with valid/ready on both sides and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int XLEN              = 32,
    parameter int BUF_DEPTH         = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] input_instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [6:0]                   out_opcode,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic [XLEN-1:0]              out_imm,
    output logic [2:0]                   out_type,
    output logic                         out_illegal,
    output logic [CNT_WIDTH-1:0]         decode_count
);

    localparam int               c_PTR_W = $clog2(BUF_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(BUF_DEPTH);

    localparam logic [2:0] c_T_R   = 3'd0;
    localparam logic [2:0] c_T_I   = 3'd1;
    localparam logic [2:0] c_T_S   = 3'd2;
    localparam logic [2:0] c_T_B   = 3'd3;
    localparam logic [2:0] c_T_U   = 3'd4;
    localparam logic [2:0] c_T_J   = 3'd5;
    localparam logic [2:0] c_T_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            illegal;
    } entry_t;

    entry_t                 w_dec;
    logic [31:0]            w_ins;
    logic [31:0]            w_imm32;
    logic                   w_push;
    logic                   w_pop;

    entry_t                 r_buf [BUF_DEPTH];
    logic [c_PTR_W-1:0]     r_wr;
    logic [c_PTR_W-1:0]     r_rd;
    logic [c_PTR_W:0]       r_count;
    logic [CNT_WIDTH-1:0]   r_dcnt;

    assign w_ins = input_instruction[31:0];

    // Every supported opcode ends in 2'b11, so a bad length field lands in the
    // illegal default without a separate check.
    always_comb begin
        w_dec        = '0;
        w_imm32      = '0;
        w_dec.opcode = w_ins[6:0];
        case (w_ins[6:0])
            7'b0110011, 7'b0101111:                         w_dec.typ = c_T_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_dec.typ = c_T_I;
            7'b0100011:                                     w_dec.typ = c_T_S;
            7'b1100011:                                     w_dec.typ = c_T_B;
            7'b0010111, 7'b0110111:                         w_dec.typ = c_T_U;
            7'b1101111:                                     w_dec.typ = c_T_J;
            default:                                        w_dec.typ = c_T_ILL;
        endcase
        w_dec.illegal = (w_dec.typ == c_T_ILL);

        if (w_dec.typ inside {c_T_R, c_T_I, c_T_U, c_T_J}) w_dec.rd = w_ins[11:7];
        if (w_dec.typ inside {c_T_R, c_T_I, c_T_S, c_T_B}) begin
            w_dec.rs1    = w_ins[19:15];
            w_dec.funct3 = w_ins[14:12];
        end
        if (w_dec.typ inside {c_T_R, c_T_S, c_T_B}) w_dec.rs2 = w_ins[24:20];
        if (w_dec.typ == c_T_R) w_dec.funct7 = w_ins[31:25];

        case (w_dec.typ)
            c_T_I:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            c_T_S:   w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            c_T_B:   w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            c_T_U:   w_imm32 = {w_ins[31:12], 12'b0};
            c_T_J:   w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
        w_dec.imm = XLEN'($signed(w_imm32));
    end

    assign in_ready  = (r_count < c_FULL) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_dcnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_buf[r_wr] <= w_dec;
                    r_wr        <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            // w_push is already gated off during flush via in_ready.
            if (w_push && (r_dcnt != {CNT_WIDTH{1'b1}})) begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign out_opcode   = r_buf[r_rd].opcode;
    assign out_rd       = r_buf[r_rd].rd;
    assign out_rs1      = r_buf[r_rd].rs1;
    assign out_rs2      = r_buf[r_rd].rs2;
    assign out_funct3   = r_buf[r_rd].funct3;
    assign out_funct7   = r_buf[r_rd].funct7;
    assign out_imm      = r_buf[r_rd].imm;
    assign out_type     = r_buf[r_rd].typ;
    assign out_illegal  = r_buf[r_rd].illegal;
    assign decode_count = r_dcnt;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage: vector table, directed corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

    localparam int XLEN      = 32;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          input_instruction;
    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           out_opcode;
    logic [4:0]           out_rd;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [XLEN-1:0]      out_imm;
    logic [2:0]           out_type;
    logic                 out_illegal;
    logic [CNT_WIDTH-1:0] decode_count;

    id_stage #(
        .INSTRUCTION_WIDTH(32),
        .XLEN             (XLEN),
        .BUF_DEPTH        (BUF_DEPTH),
        .CNT_WIDTH        (CNT_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .input_instruction(input_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_opcode       (out_opcode),
        .out_rd           (out_rd),
        .out_rs1          (out_rs1),
        .out_rs2          (out_rs2),
        .out_funct3       (out_funct3),
        .out_funct7       (out_funct7),
        .out_imm          (out_imm),
        .out_type         (out_type),
        .out_illegal      (out_illegal),
        .decode_count     (decode_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        d;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    dec_t q[$];
    int   dcnt = 0;
    logic [6:0] ops [11] = '{7'h33, 7'h2F, 7'h13, 7'h03, 7'h67, 7'h73,
                             7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the format rules, immediates built arithmetically.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int   s;
        int   v;
        s = int'(i);
        d = '{default: '0};
        d.opcode = i[6:0];
        case (i[6:0])
            7'h33, 7'h2F:               d.typ = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: d.typ = 3'd1;
            7'h23:                      d.typ = 3'd2;
            7'h63:                      d.typ = 3'd3;
            7'h17, 7'h37:               d.typ = 3'd4;
            7'h6F:                      d.typ = 3'd5;
            default:                    d.typ = 3'd7;
        endcase
        d.ill = (d.typ == 3'd7);
        if (d.typ == 0 || d.typ == 1 || d.typ == 4 || d.typ == 5) d.rd = i[11:7];
        if (d.typ <= 3) begin
            d.rs1 = i[19:15];
            d.f3  = i[14:12];
        end
        if (d.typ == 0 || d.typ == 2 || d.typ == 3) d.rs2 = i[24:20];
        if (d.typ == 0) d.f7 = i[31:25];
        case (d.typ)
            3'd1:    v = s >>> 20;
            3'd2:    v = (s >>> 25) * 32 + int'(i[11:7]);
            3'd3:    v = (s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            3'd4:    v = int'(i & 32'hFFFF_F000);
            3'd5:    v = (s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        d.imm = 32'(v);
        return d;
    endfunction

    task automatic chk_head(input string tag, input dec_t e);
        chk({tag, ".opcode"},  out_opcode,  e.opcode);
        chk({tag, ".rd"},      out_rd,      e.rd);
        chk({tag, ".rs1"},     out_rs1,     e.rs1);
        chk({tag, ".rs2"},     out_rs2,     e.rs2);
        chk({tag, ".funct3"},  out_funct3,  e.f3);
        chk({tag, ".funct7"},  out_funct7,  e.f7);
        chk({tag, ".imm"},     out_imm,     e.imm);
        chk({tag, ".type"},    out_type,    e.typ);
        chk({tag, ".illegal"}, out_illegal, e.ill);
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic tick(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic fl, input logic r);
        logic exp_rdy;
        logic push;
        logic pop;
        @(negedge clk);
        in_valid = v; input_instruction = ins; out_ready = rdy; flush = fl; rst = r;
        #1;
        exp_rdy = (q.size() < BUF_DEPTH) && !fl;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, q.size() != 0);
        chk("decode_count", decode_count, dcnt);
        if (q.size() != 0) chk_head("head", q[0]);
        push = v && exp_rdy;
        pop  = (q.size() != 0) && rdy;
        if (r) begin
            q.delete();
            dcnt = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ref_decode(ins));
                if (dcnt < CNT_MAX) dcnt++;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w  = $urandom();
        op = ($urandom_range(0, 5) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 10)];
        w[6:0] = op;
        return w;
    endfunction

    vec_t vt [7];

    initial begin
        vt[0] = '{32'hFFF1_0093, '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 3'd1, 1'b0}};
        vt[1] = '{32'h0053_2423, '{7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'h00, 32'h0000_0008, 3'd2, 1'b0}};
        vt[2] = '{32'hFFDF_F06F, '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 3'd5, 1'b0}};
        vt[3] = '{32'h1234_51B7, '{7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 3'd4, 1'b0}};
        vt[4] = '{32'h0000_007F, '{7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 3'd7, 1'b1}};
        vt[5] = '{32'h4020_81B3, '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 3'd0, 1'b0}};
        vt[6] = '{32'hFE20_8EE3, '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 3'd3, 1'b0}};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; input_instruction = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.decode_count", decode_count, '0);
        chk_head("rst", '{default: '0});

        // Table: push each vector, then hold it with out_ready=0 and compare constants.
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, vt[k].instr, 1'b1, 1'b0, 1'b0);
            tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk_head($sformatf("vec%0d", k), vt[k].d);
            chk($sformatf("vec%0d.count", k), decode_count, k + 1);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: fill, an extra push is refused, then drain in order.
        for (int k = 0; k <= BUF_DEPTH; k++) tick(1'b1, vt[k].instr, 1'b0, 1'b0, 1'b0);
        #1 chk("full.in_ready", in_ready, 1'b0);
        for (int k = 0; k <= BUF_DEPTH; k++) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with two entries buffered and an instruction presented.
        tick(1'b1, vt[3].instr, 1'b0, 1'b0, 1'b0);
        tick(1'b1, vt[5].instr, 1'b0, 1'b0, 1'b0);
        tick(1'b1, vt[6].instr, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush.out_valid", out_valid, 1'b0);

        // Counter saturation, then reset mid-stream.
        for (int k = 0; k < 20; k++) tick(1'b1, vt[k % 7].instr, 1'b1, 1'b0, 1'b0);
        tick(1'b1, vt[0].instr, 1'b1, 1'b0, 1'b0);
        chk("sat.decode_count", decode_count, CNT_MAX);
        tick(1'b1, vt[1].instr, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.decode_count", decode_count, '0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            tick(1'($urandom_range(0, 1)), rand_instr(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 79) == 0));
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised successor to the combinational instruction decoder `id`.
- Decodes each accepted RV32I/RV-A instruction at the input (fields, immediate, format class, illegal flag). Stores the decoded result in a BUF_DEPTH-entry in-order buffer.
- Presents decoded entries downstream with valid/ready handshakes on both sides, a pipeline flush, and a saturating decode counter.
- Sits between fetch and register-read/execute.

Parameters:
- INSTRUCTION_WIDTH, 32, instruction word width; fixed at 32, other values unsupported.
- XLEN, 32, immediate output width; 32 or 64; immediates sign-extended to XLEN.
- BUF_DEPTH, 2, decoded-entry buffer depth; power of two, >=2.
- CNT_WIDTH, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered entries; takes priority over push.
- in_valid  input  1  input_instruction is valid.
- in_ready  output  1  buffer can accept; equals (count < BUF_DEPTH) && !flush.
- input_instruction  input  INSTRUCTION_WIDTH  raw instruction word.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  downstream consumes head.
- out_opcode  output  7  head instr[6:0].
- out_rd  output  5  destination register; 0 for S/B/illegal.
- out_rs1  output  5  source 1; 0 for U/J/illegal.
- out_rs2  output  5  source 2; 0 for I/U/J/illegal.
- out_funct3  output  3  instr[14:12]; 0 for U/J/illegal.
- out_funct7  output  7  instr[31:25] for R only, else 0.
- out_imm  output  XLEN  decoded, sign-extended immediate; 0 for R/illegal.
- out_type  output  3  format class: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  output  1  head opcode not in supported set, or instr[1:0] != 2'b11.
- decode_count  output  CNT_WIDTH  number of accepted pushes; saturates at all-ones.

Behaviour:
- Reset (rst=1 at posedge):
  - count = 0, read/write pointers = 0, decode_count = 0.
  - All buffer storage cleared, so every out_* field reads 0.
  - out_valid = 0; in_ready = 1 from the first cycle after reset.
- Opcode to class mapping:
  - 0110011 and 0101111 -> R.
  - 0010011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0010111 and 0110111 -> U.
  - 1101111 -> J.
  - Anything else -> illegal.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Push: on posedge with in_valid && in_ready, the decode of input_instruction is written at the write pointer. Write pointer wraps modulo BUF_DEPTH.
- Pop: on posedge with out_valid && out_ready, the read pointer advances, also wrapping.
- Latency: a pushed entry appears on out_* the cycle after the push edge when the buffer was empty. Otherwise it appears after all older entries have popped. Order is strictly FIFO.
- out_* are driven combinationally from the head entry and are stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, in_ready = 0, so there is no same-cycle pass-through.
- Empty: out_valid = 0. out_* show the stale head slot and have no meaning.
- Full: count = BUF_DEPTH, in_ready = 0; in_valid is ignored and the input is not captured.
- Flush:
  - At the next posedge, count and both pointers go to 0 and out_valid = 0.
  - in_ready = 0 during the flush cycle, so a presented instruction is dropped and decode_count does not increment.
  - A pop handshake in the flush cycle is irrelevant, because the buffer empties regardless.
- decode_count: increments by 1 per push, including illegal entries; holds at 2^CNT_WIDTH-1. Cleared only by rst; flush does not clear it.
- rst mid-operation: all buffered entries are lost and the state equals the post-reset state.
- rst overrides flush and all handshakes.

Test Plan:
- Reset, then push ADDI x1,x2,-1 (0xFFF10093) with out_ready=1 -> next cycle out_valid=1, type=1, rd=1, rs1=2, rs2=0, funct3=0, imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF); decode_count=1.
- Push SW x5,8(x6) (0x00532423), JAL x0,-4 (0xFFDFF06F), LUI x3,0x12345 (0x123451B7) back to back with out_ready=1:
  - SW -> type=2, rs1=6, rs2=5, rd=0, imm=8.
  - JAL -> type=5, rd=0, imm=0xFFFFFFFC.
  - LUI -> type=4, rd=3, imm=0x12345000.
- Push 0x0000007F -> out_illegal=1, type=7, rd=rs1=rs2=0, imm=0; decode_count still increments.
- Hold out_ready=0 and push BUF_DEPTH instructions -> in_ready=0 once full; a further in_valid is ignored. Release out_ready -> entries drain in push order; pointer wrap verified over 3*BUF_DEPTH pushes.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0, and the flush-cycle instruction is never output.
- CNT_WIDTH=4, push 20 instructions -> decode_count saturates at 15. Then rst mid-stream -> out_valid=0 and decode_count=0 the next cycle.
